// File: rtl/decoder_pkg.sv
// Decoder-wide definitions: load/store size codes, LSU state type and the alignment rule.
package decoder_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] LDST_B  = 3'b000;
    localparam logic [2:0] LDST_H  = 3'b001;
    localparam logic [2:0] LDST_W  = 3'b010;
    localparam logic [2:0] LDST_BU = 3'b100;
    localparam logic [2:0] LDST_HU = 3'b101;

    typedef enum logic {
        IDLE,
        WAIT
    } lsu_state_t;

    // Unlisted size codes are treated as word accesses.
    function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (size)
            LDST_B, LDST_BU: mis = 1'b0;
            LDST_H, LDST_HU: mis = off[0];
            default:         mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/riscv_lsu_lane_align.sv
// Lane steering: byte enables and write-data replication for stores, extension for loads.
module lsu_lane_align
    import decoder_pkg::*;
(
    input  logic [2:0]      st_size,
    input  logic [1:0]      st_off,
    input  logic [XLEN-1:0] st_wd,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wd,
    input  logic [2:0]      ld_size,
    input  logic [1:0]      ld_off,
    input  logic [XLEN-1:0] ld_word,
    output logic [XLEN-1:0] ld_data
);

    logic [XLEN-1:0] byte_shift;
    logic [XLEN-1:0] half_shift;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;

    always_comb begin
        be = 4'b1111;
        wd = st_wd;
        case (st_size)
            LDST_B, LDST_BU: begin
                be = 4'b0001 << st_off;
                wd = {4{st_wd[7:0]}};
            end
            LDST_H, LDST_HU: begin
                be = 4'b0011 << {st_off[1], 1'b0};
                wd = {2{st_wd[15:0]}};
            end
            default: begin
                be = 4'b1111;
                wd = st_wd;
            end
        endcase
    end

    assign byte_shift = ld_word >> {ld_off, 3'b000};
    assign half_shift = ld_word >> {ld_off[1], 4'b0000};
    assign ld_byte    = byte_shift[7:0];
    assign ld_half    = half_shift[15:0];

    always_comb begin
        ld_data = ld_word;
        case (ld_size)
            LDST_B:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            LDST_BU: ld_data = {24'h000000, ld_byte};
            LDST_H:  ld_data = {{16{ld_half[15]}}, ld_half};
            LDST_HU: ld_data = {16'h0000, ld_half};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: single outstanding data-memory access with stall, misalign and timeout reporting.
module riscv_lsu
    import decoder_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            core_req_i,
    input  logic            core_we_i,
    input  logic [2:0]      core_size_i,
    input  logic [XLEN-1:0] core_addr_i,
    input  logic [XLEN-1:0] core_wd_i,
    output logic [XLEN-1:0] core_rd_o,
    output logic            core_stall_o,
    output logic            misalign_o,
    output logic            fault_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [3:0]      mem_be_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_wd_o,
    input  logic [XLEN-1:0] mem_rd_i,
    input  logic            mem_ready_i
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic            req_q, we_q;
    logic [3:0]      be_q;
    logic [XLEN-1:0] addr_q, wd_q;
    logic [2:0]      size_q;
    logic [1:0]      off_q;

    logic            accept, done, timeout, misal;
    logic [3:0]      be_c;
    logic [XLEN-1:0] wd_c, ld_data_c;

    lsu_lane_align u_lane_align (
        .st_size (core_size_i),
        .st_off  (core_addr_i[1:0]),
        .st_wd   (core_wd_i),
        .be      (be_c),
        .wd      (wd_c),
        .ld_size (size_q),
        .ld_off  (off_q),
        .ld_word (mem_rd_i),
        .ld_data (ld_data_c)
    );

    assign misal = is_misaligned(core_size_i, core_addr_i[1:0]);

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state and core-facing handshake; ready takes priority over timeout.
    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        done         = 1'b0;
        timeout      = 1'b0;
        core_stall_o = 1'b0;
        misalign_o   = 1'b0;
        fault_o      = 1'b0;
        core_rd_o    = '0;
        case (state_q)
            IDLE: begin
                if (core_req_i) begin
                    if (misal) begin
                        misalign_o = 1'b1;
                    end else begin
                        core_stall_o = 1'b1;
                        accept       = 1'b1;
                        state_d      = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem_ready_i) begin
                    done    = 1'b1;
                    state_d = IDLE;
                    if (!we_q) core_rd_o = ld_data_c;
                end else if (cnt_q == CNT_LAST) begin
                    timeout = 1'b1;
                    fault_o = 1'b1;
                    state_d = IDLE;
                end else begin
                    core_stall_o = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request registers and timeout counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_q  <= 1'b0;
            we_q   <= 1'b0;
            be_q   <= '0;
            addr_q <= '0;
            wd_q   <= '0;
            size_q <= '0;
            off_q  <= '0;
            cnt_q  <= '0;
        end else if (accept) begin
            req_q  <= 1'b1;
            we_q   <= core_we_i;
            be_q   <= be_c;
            addr_q <= {core_addr_i[XLEN-1:2], 2'b00};
            wd_q   <= wd_c;
            size_q <= core_size_i;
            off_q  <= core_addr_i[1:0];
            cnt_q  <= '0;
        end else if (state_q == WAIT) begin
            if (done || timeout) begin
                req_q <= 1'b0;
                we_q  <= 1'b0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign mem_req_o  = req_q;
    assign mem_we_o   = we_q;
    assign mem_be_o   = be_q;
    assign mem_addr_o = addr_q;
    assign mem_wd_o   = wd_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu: vector table, corner sequences and randomized accesses.
module tb_riscv_lsu;
    import decoder_pkg::*;

    localparam int unsigned TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        core_req_i, core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i, core_wd_i, core_rd_o;
    logic        core_stall_o, misalign_o, fault_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wd_o, mem_rd_i;
    logic        mem_ready_i;

    riscv_lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .core_req_i(core_req_i), .core_we_i(core_we_i), .core_size_i(core_size_i),
        .core_addr_i(core_addr_i), .core_wd_i(core_wd_i), .core_rd_o(core_rd_o),
        .core_stall_o(core_stall_o), .misalign_o(misalign_o), .fault_o(fault_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o), .mem_rd_i(mem_rd_i),
        .mem_ready_i(mem_ready_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: byte-level view of the access.
    function automatic int nbytes(input logic [2:0] s);
        if (s == LDST_B || s == LDST_BU) return 1;
        if (s == LDST_H || s == LDST_HU) return 2;
        return 4;
    endfunction

    function automatic int lane_base(input logic [2:0] s, input logic [31:0] a);
        int off;
        off = int'(a % 32'd4);
        return off - (off % nbytes(s));
    endfunction

    function automatic logic ref_misal(input logic [2:0] s, input logic [31:0] a);
        return (a % 32'(nbytes(s))) != 0;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] s, input logic [31:0] a);
        logic [3:0] be;
        int b, n;
        b = lane_base(s, a);
        n = nbytes(s);
        be = '0;
        for (int i = 0; i < 4; i++) be[i] = (i >= b) && (i < b + n);
        return be;
    endfunction

    function automatic logic [31:0] ref_wd(input logic [2:0] s, input logic [31:0] wd);
        logic [31:0] r;
        int n;
        n = nbytes(s);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [2:0] s, input logic [31:0] a,
                                          input logic [31:0] word);
        longint v, span;
        int n;
        n = nbytes(s);
        if (n == 4) return word;
        span = longint'(1) << (8 * n);
        v = longint'(word >> (8 * lane_base(s, a))) % span;
        if ((s == LDST_B || s == LDST_H) && v >= span / 2) v = v - span;
        return 32'(v);
    endfunction

    // One access starting with the DUT idle, just after a rising edge.
    task automatic run_access(input string tag, input logic we, input logic [2:0] sz,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] rdata, input int delay,
                              input logic exp_mis, input logic [3:0] exp_be,
                              input logic [31:0] exp_wd, input logic [31:0] exp_rd);
        core_req_i = 1'b1; core_we_i = we; core_size_i = sz;
        core_addr_i = addr; core_wd_i = wd; mem_ready_i = 1'b0;
        #1;
        chk({tag, " misalign"}, 32'(misalign_o), 32'(exp_mis));
        if (exp_mis) begin
            chk({tag, " stall_mis"}, 32'(core_stall_o), 32'd0);
            @(posedge clk_i); #1;
            chk({tag, " no_req"}, 32'(mem_req_o), 32'd0);
            core_req_i = 1'b0;
            return;
        end
        chk({tag, " stall_req"}, 32'(core_stall_o), 32'd1);
        @(posedge clk_i); #1;
        chk({tag, " mem_req"}, 32'(mem_req_o), 32'd1);
        chk({tag, " mem_we"}, 32'(mem_we_o), 32'(we));
        chk({tag, " be"}, 32'(mem_be_o), 32'(exp_be));
        chk({tag, " addr"}, mem_addr_o, addr & 32'hFFFF_FFFC);
        if (we) chk({tag, " wd"}, mem_wd_o, exp_wd);
        for (int i = 0; i < delay; i++) begin
            chk({tag, " stall_wait"}, 32'(core_stall_o), 32'd1);
            @(posedge clk_i); #1;
        end
        mem_ready_i = 1'b1; mem_rd_i = rdata;
        #1;
        chk({tag, " stall_done"}, 32'(core_stall_o), 32'd0);
        chk({tag, " rd"}, core_rd_o, exp_rd);
        chk({tag, " fault"}, 32'(fault_o), 32'd0);
        @(posedge clk_i); #1;
        mem_ready_i = 1'b0; core_req_i = 1'b0;
        chk({tag, " req_drop"}, 32'(mem_req_o), 32'd0);
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  sz;
        logic [31:0] addr, wd, rdata;
        int          delay;
        logic        exp_mis;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd, exp_rd;
    } vec_t;

    vec_t vt[10];

    initial begin
        logic        r_we;
        logic [2:0]  r_sz;
        logic [31:0] r_addr, r_wd, r_rd;
        logic [2:0]  sizes[5];

        vt[0] = '{"sw104",  1'b1, LDST_W,  32'h104, 32'hDEADBEEF, 32'h0,         1, 1'b0, 4'b1111, 32'hDEADBEEF, 32'h0};
        vt[1] = '{"sb103",  1'b1, LDST_B,  32'h103, 32'h000000A5, 32'h0,         0, 1'b0, 4'b1000, 32'hA5A5A5A5, 32'h0};
        vt[2] = '{"lb102",  1'b0, LDST_B,  32'h102, 32'h0,        32'h00800000,  0, 1'b0, 4'b0100, 32'h0, 32'hFFFFFF80};
        vt[3] = '{"lbu102", 1'b0, LDST_BU, 32'h102, 32'h0,        32'h00800000,  2, 1'b0, 4'b0100, 32'h0, 32'h00000080};
        vt[4] = '{"lh101",  1'b0, LDST_H,  32'h101, 32'h0,        32'h0,         0, 1'b1, 4'b0000, 32'h0, 32'h0};
        vt[5] = '{"lhu102", 1'b0, LDST_HU, 32'h102, 32'h0,        32'h80010000,  0, 1'b0, 4'b1100, 32'h0, 32'h00008001};
        vt[6] = '{"lh000",  1'b0, LDST_H,  32'h000, 32'h0,        32'h00008001,  1, 1'b0, 4'b0011, 32'h0, 32'hFFFF8001};
        vt[7] = '{"sh106",  1'b1, LDST_H,  32'h106, 32'h1234ABCD, 32'h0,         0, 1'b0, 4'b1100, 32'hABCDABCD, 32'h0};
        vt[8] = '{"lw_rdy_to", 1'b0, LDST_W, 32'h010, 32'h0,      32'h12345678,  3, 1'b0, 4'b1111, 32'h0, 32'h12345678};
        vt[9] = '{"sw002",  1'b1, LDST_W,  32'h002, 32'h11111111, 32'h0,         0, 1'b1, 4'b0000, 32'h0, 32'h0};

        rst_i = 1'b1; core_req_i = 1'b0; core_we_i = 1'b0; core_size_i = LDST_W;
        core_addr_i = '0; core_wd_i = '0; mem_rd_i = '0; mem_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst mem_req", 32'(mem_req_o), 32'd0);
        chk("rst mem_we", 32'(mem_we_o), 32'd0);
        chk("rst be", 32'(mem_be_o), 32'd0);
        chk("rst addr", mem_addr_o, 32'd0);
        chk("rst wd", mem_wd_o, 32'd0);
        chk("rst fault", 32'(fault_o), 32'd0);
        chk("rst stall", 32'(core_stall_o), 32'd0);
        chk("rst rd", core_rd_o, 32'd0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        for (int i = 0; i < 10; i++)
            run_access(vt[i].name, vt[i].we, vt[i].sz, vt[i].addr, vt[i].wd, vt[i].rdata,
                       vt[i].delay, vt[i].exp_mis, vt[i].exp_be, vt[i].exp_wd, vt[i].exp_rd);

        // Timeout: no ready for TO WAIT cycles.
        core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = LDST_W; core_addr_i = 32'h20;
        #1;
        chk("to stall_req", 32'(core_stall_o), 32'd1);
        @(posedge clk_i); #1;
        for (int k = 1; k <= int'(TO); k++) begin
            chk("to mem_req", 32'(mem_req_o), 32'd1);
            if (k < int'(TO)) begin
                chk("to fault_early", 32'(fault_o), 32'd0);
                chk("to stall_wait", 32'(core_stall_o), 32'd1);
                @(posedge clk_i); #1;
            end else begin
                chk("to fault", 32'(fault_o), 32'd1);
                chk("to stall_fault", 32'(core_stall_o), 32'd0);
                chk("to rd", core_rd_o, 32'd0);
            end
        end
        core_req_i = 1'b0;
        @(posedge clk_i); #1;
        chk("to idle_req", 32'(mem_req_o), 32'd0);
        chk("to fault_pulse", 32'(fault_o), 32'd0);

        // Reset in the second WAIT cycle abandons the access.
        core_req_i = 1'b1; core_we_i = 1'b0; core_size_i = LDST_W; core_addr_i = 32'h30;
        @(posedge clk_i); #1;
        chk("rw wait1_stall", 32'(core_stall_o), 32'd1);
        @(posedge clk_i); #1;
        rst_i = 1'b1; core_req_i = 1'b0;
        #1;
        chk("rw fault_rst", 32'(fault_o), 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        chk("rw req_after", 32'(mem_req_o), 32'd0);
        chk("rw fault_after", 32'(fault_o), 32'd0);
        run_access("rw lw", 1'b0, LDST_W, 32'h44, 32'h0, 32'hCAFEF00D, 1,
                   1'b0, 4'b1111, 32'h0, 32'hCAFEF00D);

        // Randomized accesses against the byte-level model.
        sizes[0] = LDST_B; sizes[1] = LDST_H; sizes[2] = LDST_W;
        sizes[3] = LDST_BU; sizes[4] = LDST_HU;
        for (int n = 0; n < 60; n++) begin
            r_we   = 1'($urandom_range(0, 1));
            r_sz   = sizes[$urandom_range(0, 4)];
            r_addr = $urandom & 32'h0000_0FFF;
            r_wd   = $urandom;
            r_rd   = $urandom;
            run_access("rnd", r_we, r_sz, r_addr, r_wd, r_rd, int'($urandom_range(0, 3)),
                       ref_misal(r_sz, r_addr), ref_be(r_sz, r_addr), ref_wd(r_sz, r_wd),
                       r_we ? 32'h0 : ref_rd(r_sz, r_addr, r_rd));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
